display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 90 +++++++++
 tb/tb_display_scan.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Seven-segment display scanner: cycles a 2-bit digit select and drives anodes, segments and dp.
// Optional leading-zero blanking on the minutes digit via the DISPLAY_SCAN_LZB_EN macro.
module display_scan #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic       clk_mux,
  input  logic       rst_mux,
  input  logic       en_in,
  input  logic [3:0] digit_in,
  output logic [1:0] sel_out,
  output logic [3:0] an_out,
  output logic [6:0] seg_out,
  output logic       dp_out
);

  localparam int unsigned     CNT_W    = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  // XOR masks that map internal active-high values onto the pin polarity.
  localparam logic [3:0]      AN_MASK  = {4{ACTIVE_LOW}};
  localparam logic [6:0]      SEG_MASK = {7{ACTIVE_LOW}};

  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic [3:0]       stage_an;
  logic [6:0]       glyph;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hF:    seg = 7'b0000000;
      default: seg = 7'b1000000;
    endcase
    return seg;
  endfunction

  // NOTE: every signal assigned in always_comb gets an unconditional default first, so no latch is inferred.
  always_comb begin
    glyph = decode(digit_in);
`ifdef DISPLAY_SCAN_LZB_EN
    if (stage_an[2] && digit_in == 4'h0) glyph = 7'b0000000;
`endif
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_mux or posedge rst_mux) begin
    if (rst_mux) begin
      cnt      <= '0;
      sel_out  <= 2'b01;
      armed    <= 1'b0;
      stage_an <= '0;
      an_out   <= AN_MASK;
      seg_out  <= SEG_MASK;
      dp_out   <= ACTIVE_LOW;
    end else begin
      // The first edge after release only arms the anode stage, so a[0] lights on the third edge.
      armed <= 1'b1;
      if (en_in) begin
        if (cnt == CNT_LAST) begin
          cnt     <= '0;
          sel_out <= sel_out + 2'd1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        // Stage one tracks the select one cycle late, aligning with the mux register's digit.
        stage_an <= armed ? (4'b0001 << (sel_out - 2'd1)) : 4'b0000;
        an_out   <= stage_an ^ AN_MASK;
        seg_out  <= ((stage_an != 4'b0000) ? glyph : 7'b0000000) ^ SEG_MASK;
        dp_out   <= stage_an[2] ^ ACTIVE_LOW;
      end else begin
        stage_an <= '0;
        an_out   <= AN_MASK;
        seg_out  <= SEG_MASK;
        dp_out   <= ACTIVE_LOW;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: arithmetic reference model of scan order and pipeline timing,
// with the external digit mux modelled as a one-cycle register of sel_out.
module tb_display_scan;

  localparam int DWELL = 4;
  localparam bit AL    = 1'b1;
`ifdef DISPLAY_SCAN_LZB_EN
  localparam bit LZB   = 1'b1;
`else
  localparam bit LZB   = 1'b0;
`endif

  logic       clk_mux = 1'b0;
  logic       rst_mux;
  logic       en_in;
  logic [3:0] digit_in;
  logic [1:0] sel_out;
  logic [3:0] an_out;
  logic [6:0] seg_out;
  logic       dp_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference glyphs {g,f,e,d,c,b,a}, active-high, indexed by digit code.
  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00};
  logic [1:0] sel_order [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  int         an_of_sel [4] = '{3, 0, 1, 2};
  logic [3:0] digits [4];   // digit supplied by the external mux, indexed by select code

  // Reference model state
  int         cyc;
  int         en_count;
  logic       prev_en;
  logic [1:0] m_sel;
  logic [1:0] prev_sel;
  logic [1:0] e_sel;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  display_scan #(.DWELL_CYCLES(DWELL), .ACTIVE_LOW(AL)) dut (
    .clk_mux (clk_mux),
    .rst_mux (rst_mux),
    .en_in   (en_in),
    .digit_in(digit_in),
    .sel_out (sel_out),
    .an_out  (an_out),
    .seg_out (seg_out),
    .dp_out  (dp_out)
  );

  always #5 clk_mux = ~clk_mux;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    cyc      = 0;
    en_count = 0;
    prev_en  = 1'b0;
    m_sel    = 2'b01;
    prev_sel = 2'b01;
    e_sel    = 2'b01;
    e_an     = AL ? 4'hF : 4'h0;
    e_seg    = AL ? 7'h7F : 7'h00;
    e_dp     = AL;
  endtask

  // One clock: drive en, advance the model by one edge, then update the mux register.
  task automatic step(input logic en);
    logic [1:0] mux_sel;
    logic [3:0] dig;
    int         pos;
    en_in   = en;
    mux_sel = sel_out;
    dig     = digit_in;
    @(posedge clk_mux);
    #1;
    cyc++;
    if (cyc >= 3 && en && prev_en) begin
      pos   = an_of_sel[prev_sel];
      e_an  = 4'(1 << pos);
      e_seg = (LZB && pos == 2 && dig == 4'h0) ? 7'h00 : glyph_tbl[dig];
      e_dp  = (pos == 2);
    end else begin
      e_an  = 4'h0;
      e_seg = 7'h00;
      e_dp  = 1'b0;
    end
    if (AL) begin
      e_an  = ~e_an;
      e_seg = ~e_seg;
      e_dp  = ~e_dp;
    end
    prev_en  = en;
    prev_sel = m_sel;
    if (en) en_count++;
    m_sel    = sel_order[(en_count / DWELL) % 4];
    e_sel    = m_sel;
    digit_in = digits[mux_sel];
  endtask

  task automatic test_reset();
    rst_mux  = 1'b1;
    en_in    = 1'b1;
    digit_in = 4'hF;
    #12;
    if (sel_out !== 2'b01) begin n_fail++; $display("FAIL reset_sel got=%b exp=01", sel_out); end
    if (an_out !== 4'hF) begin n_fail++; $display("FAIL reset_an got=%b exp=1111", an_out); end
    if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got=%b exp=1111111", seg_out); end
    if (dp_out !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b exp=1", dp_out); end
    n_checks += 4;
    @(negedge clk_mux);
    rst_mux = 1'b0;
    model_reset();
  endtask

  task automatic test_sequence();
    logic [1:0] last;
    int run_len;
    digits[1] = 4'h5; digits[2] = 4'h3; digits[3] = 4'h7; digits[0] = 4'hF;
    last    = sel_out;
    run_len = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (sel_out !== e_sel) begin n_fail++; $display("FAIL seq_sel cyc=%0d got=%b exp=%b", cyc, sel_out, e_sel); end
      if (an_out !== e_an) begin n_fail++; $display("FAIL seq_an cyc=%0d got=%b exp=%b", cyc, an_out, e_an); end
      if (seg_out !== e_seg) begin n_fail++; $display("FAIL seq_seg cyc=%0d got=%b exp=%b", cyc, seg_out, e_seg); end
      if (dp_out !== e_dp) begin n_fail++; $display("FAIL seq_dp cyc=%0d got=%b exp=%b", cyc, dp_out, e_dp); end
      n_checks += 4;
      if (sel_out === last) begin
        run_len++;
      end else begin
        if (run_len !== DWELL) begin n_fail++; $display("FAIL seq_dwell cyc=%0d got=%0d exp=%0d", cyc, run_len, DWELL); end
        n_checks++;
        run_len = 1;
        last    = sel_out;
      end
      if (cyc == 2) begin
        if (an_out !== 4'hF) begin n_fail++; $display("FAIL first_light_early got=%b exp=1111", an_out); end
        n_checks++;
      end
      if (cyc == 3) begin
        if (an_out !== 4'b1110) begin n_fail++; $display("FAIL first_light_an got=%b exp=1110", an_out); end
        if (seg_out !== 7'b0010010) begin n_fail++; $display("FAIL digit5_seg got=%b exp=0010010", seg_out); end
        n_checks += 2;
      end
    end
  endtask

  task automatic test_blank_dash();
    int found_f;
    int found_b;
    found_f = 0;
    found_b = 0;
    for (int pass = 0; pass < 2; pass++) begin
      digits[0] = (pass == 0) ? 4'hF : 4'hB;
      for (int i = 0; i < 18; i++) begin
        step(1'b1);
        if (sel_out !== e_sel) begin n_fail++; $display("FAIL blank_sel cyc=%0d got=%b exp=%b", cyc, sel_out, e_sel); end
        if (an_out !== e_an) begin n_fail++; $display("FAIL blank_an cyc=%0d got=%b exp=%b", cyc, an_out, e_an); end
        if (seg_out !== e_seg) begin n_fail++; $display("FAIL blank_seg cyc=%0d got=%b exp=%b", cyc, seg_out, e_seg); end
        n_checks += 3;
        if (i >= 2 && an_out === 4'b0111) begin
          if (pass == 0) begin
            found_f++;
            if (seg_out !== 7'b1111111) begin n_fail++; $display("FAIL null_blank got=%b exp=1111111", seg_out); end
          end else begin
            found_b++;
            if (seg_out !== 7'b0111111) begin n_fail++; $display("FAIL null_dash got=%b exp=0111111", seg_out); end
          end
          n_checks++;
        end
      end
    end
    if (found_f == 0 || found_b == 0) begin
      n_fail++; $display("FAIL null_frame_seen got=%0d/%0d exp=nonzero", found_f, found_b);
    end
    n_checks++;
  endtask

  task automatic test_enable();
    logic [1:0] held;
    int guard;
    guard = 0;
    while ((en_count % DWELL) != 2 && guard < 8) begin
      step(1'b1);
      guard++;
    end
    if ((en_count % DWELL) != 2) begin n_fail++; $display("FAIL en_setup got=%0d exp=2", en_count % DWELL); end
    n_checks++;
    held = sel_out;
    step(1'b0);
    if (an_out !== 4'hF) begin n_fail++; $display("FAIL en_off_an got=%b exp=1111", an_out); end
    if (seg_out !== e_seg) begin n_fail++; $display("FAIL en_off_seg got=%b exp=%b", seg_out, e_seg); end
    if (dp_out !== e_dp) begin n_fail++; $display("FAIL en_off_dp got=%b exp=%b", dp_out, e_dp); end
    n_checks += 3;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1'b0);
      if (sel_out !== held) begin n_fail++; $display("FAIL en_off_hold cyc=%0d got=%b exp=%b", cyc, sel_out, held); end
      n_checks++;
    end
    step(1'b1);
    if (sel_out !== held) begin n_fail++; $display("FAIL en_resume1_sel got=%b exp=%b", sel_out, held); end
    if (an_out !== 4'hF) begin n_fail++; $display("FAIL en_resume1_an got=%b exp=1111", an_out); end
    n_checks += 2;
    step(1'b1);
    if (sel_out === held || sel_out !== e_sel) begin n_fail++; $display("FAIL en_resume2_sel got=%b exp=%b", sel_out, e_sel); end
    if (an_out === 4'hF || an_out !== e_an) begin n_fail++; $display("FAIL en_resume2_an got=%b exp=%b", an_out, e_an); end
    n_checks += 2;
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (!(m_sel == 2'b11 && (en_count % DWELL) == 1) && guard < 20) begin
      step(1'b1);
      guard++;
    end
    if (sel_out !== 2'b11 || an_out === 4'hF) begin
      n_fail++; $display("FAIL rstmid_setup got=%b/%b exp=11/lit", sel_out, an_out);
    end
    n_checks++;
    #2;
    rst_mux = 1'b1;
    #1;
    if (sel_out !== 2'b01) begin n_fail++; $display("FAIL rstmid_sel got=%b exp=01", sel_out); end
    if (an_out !== 4'hF) begin n_fail++; $display("FAIL rstmid_an got=%b exp=1111", an_out); end
    if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL rstmid_seg got=%b exp=1111111", seg_out); end
    if (dp_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_dp got=%b exp=1", dp_out); end
    n_checks += 4;
    @(posedge clk_mux);
    @(negedge clk_mux);
    rst_mux  = 1'b0;
    digit_in = 4'(($urandom % 10));
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      if (sel_out !== e_sel) begin n_fail++; $display("FAIL rstmid_run_sel cyc=%0d got=%b exp=%b", cyc, sel_out, e_sel); end
      if (an_out !== e_an) begin n_fail++; $display("FAIL rstmid_run_an cyc=%0d got=%b exp=%b", cyc, an_out, e_an); end
      if (seg_out !== e_seg) begin n_fail++; $display("FAIL rstmid_run_seg cyc=%0d got=%b exp=%b", cyc, seg_out, e_seg); end
      n_checks += 3;
    end
  endtask

  task automatic test_lzb();
    int found;
    found = 0;
    digits[3] = 4'h0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (an_out !== e_an) begin n_fail++; $display("FAIL lzb_an cyc=%0d got=%b exp=%b", cyc, an_out, e_an); end
      if (seg_out !== e_seg) begin n_fail++; $display("FAIL lzb_seg cyc=%0d got=%b exp=%b", cyc, seg_out, e_seg); end
      n_checks += 2;
      if (i >= 2 && an_out === 4'b1011) begin
        found++;
        if (seg_out !== (LZB ? 7'b1111111 : 7'b1000000)) begin
          n_fail++; $display("FAIL lzb_min_zero got=%b exp=%b", seg_out, LZB ? 7'b1111111 : 7'b1000000);
        end
        if (dp_out !== 1'b0) begin n_fail++; $display("FAIL lzb_dp got=%b exp=0", dp_out); end
        n_checks += 2;
      end
    end
    if (found == 0) begin n_fail++; $display("FAIL lzb_frame_seen got=0 exp=nonzero"); end
    n_checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (i % 7 == 0) begin
        for (int k = 0; k < 4; k++) digits[k] = 4'($urandom_range(0, 15));
      end
      step(($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0);
      if (sel_out !== e_sel) begin n_fail++; $display("FAIL rand_sel cyc=%0d got=%b exp=%b", cyc, sel_out, e_sel); end
      if (an_out !== e_an) begin n_fail++; $display("FAIL rand_an cyc=%0d got=%b exp=%b", cyc, an_out, e_an); end
      if (seg_out !== e_seg) begin n_fail++; $display("FAIL rand_seg cyc=%0d got=%b exp=%b", cyc, seg_out, e_seg); end
      if (dp_out !== e_dp) begin n_fail++; $display("FAIL rand_dp cyc=%0d got=%b exp=%b", cyc, dp_out, e_dp); end
      n_checks += 4;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) digits[k] = 4'hF;
    model_reset();
    test_reset();
    test_sequence();
    test_blank_dash();
    test_enable();
    test_reset_mid();
    test_lzb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
